// File: rtl/bios_sram_loader.sv
// bios_sram_loader
// ----------------------------------------------------------------------------
// Streams download bytes into the external BIOS SRAM before the CPU runs.
// Each accepted byte becomes one timed write cycle:
//   SETUP (SETUP_CYCLES clocks, data driven, WE_n high)
//   PULSE (WE_CYCLES clocks, WE_n low)
//   HOLD  (1 clock, data still driven, WE_n high)
// The block keeps a byte count and an 8-bit running checksum, and flags an
// overflow when MAX_BYTES have been written without seeing dl_last.
//
// Optional feature (macro BIOS_SRAM_LOADER_VERIFY_EN): after the write phase
// the loaded range is read back, the samples are summed mod 256 and compared
// against the write checksum; a difference raises error.
//
// Ports
//   clka        system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       one-clock pulse, starts a load from IDLE or DONE
//   dl_valid    download byte valid
//   dl_data     download byte
//   dl_last     final byte marker, qualified by dl_valid
//   dl_ready    block can accept a byte
//   SRAM_ADDR   SRAM address
//   SRAM_DATA   SRAM data, driven only during SETUP/PULSE/HOLD
//   SRAM_WE_n   SRAM write strobe, active low
//   sram_own    loader owns the SRAM pins
//   busy        load or verify in progress (same as sram_own)
//   done        load finished, held until next start
//   error       overflow or verify mismatch, held until next start
//   byte_count  bytes written
//   checksum    sum of written bytes, mod 256
// ----------------------------------------------------------------------------
module bios_sram_loader #(
   parameter int ADDR_W       = 21,
   parameter int BASE_ADDR    = 0,
   parameter int MAX_BYTES    = 65536,
   parameter int SETUP_CYCLES = 1,
   parameter int WE_CYCLES    = 2,
   parameter int READ_CYCLES  = 2
) (
   input  logic              clka,
   input  logic              rst_n,
   input  logic              start,
   input  logic              dl_valid,
   input  logic [7:0]        dl_data,
   input  logic              dl_last,
   output logic              dl_ready,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   inout  wire  [7:0]        SRAM_DATA,
   output logic              SRAM_WE_n,
   output logic              sram_own,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [16:0]       byte_count,
   output logic [7:0]        checksum
);

`ifdef BIOS_SRAM_LOADER_VERIFY_EN
   typedef enum logic [2:0] {
      IDLE, WAIT_DATA, SETUP, PULSE, HOLD, DONE, VRD_ADDR, VRD_SAMPLE
   } state_t;
   localparam state_t WR_END = VRD_ADDR;
`else
   typedef enum logic [2:0] {
      IDLE, WAIT_DATA, SETUP, PULSE, HOLD, DONE
   } state_t;
   localparam state_t WR_END = DONE;
`endif

   localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);

   state_t              state_q;
   state_t              state_nx;
   logic [15:0]         tmr_q;
   logic                last_q;
   logic [7:0]          byte_q;
   logic                data_oe_q;
   logic [ADDR_W-1:0]   addr_q;
   // One bit wider than byte_count so that MAX_BYTES = 2^17 is representable.
   logic [17:0]         cnt_q;
   logic [17:0]         cnt_inc;
   logic                own_nx;

   assign cnt_inc    = cnt_q + 18'd1;
   assign byte_count = cnt_q[16:0];
   assign SRAM_ADDR  = addr_q;
   assign SRAM_DATA  = data_oe_q ? byte_q : 8'bz;
   assign own_nx     = !((state_nx == IDLE) || (state_nx == DONE));

`ifdef BIOS_SRAM_LOADER_VERIFY_EN
   logic [17:0] vidx_q;
   logic [7:0]  vsum_q;
   logic [7:0]  vsum_nx;
   assign vsum_nx = vsum_q + SRAM_DATA;
`endif

   // Next-state logic
   always_comb begin
      state_nx = state_q;
      case (state_q)
         IDLE, DONE: if (start)    state_nx = WAIT_DATA;
         WAIT_DATA:  if (dl_valid) state_nx = SETUP;
         SETUP: if (tmr_q == 16'(SETUP_CYCLES - 1)) state_nx = PULSE;
         PULSE: if (tmr_q == 16'(WE_CYCLES - 1))    state_nx = HOLD;
         HOLD: begin
            // Count is at least 1 here, so the verify pass always has work.
            if (last_q || (cnt_inc == 18'(MAX_BYTES))) state_nx = WR_END;
            else                                       state_nx = WAIT_DATA;
         end
`ifdef BIOS_SRAM_LOADER_VERIFY_EN
         VRD_ADDR: if (tmr_q == 16'(READ_CYCLES - 1)) state_nx = VRD_SAMPLE;
         VRD_SAMPLE: begin
            if ((vidx_q + 18'd1) == cnt_q) state_nx = DONE;
            else                           state_nx = VRD_ADDR;
         end
`endif
         default: state_nx = IDLE;
      endcase
   end

   // State register, registered outputs and counters
   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         tmr_q     <= '0;
         last_q    <= 1'b0;
         cnt_q     <= '0;
         checksum  <= '0;
         addr_q    <= '0;
         error     <= 1'b0;
         SRAM_WE_n <= 1'b1;
         data_oe_q <= 1'b0;
         dl_ready  <= 1'b0;
         sram_own  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef BIOS_SRAM_LOADER_VERIFY_EN
         vidx_q    <= '0;
`endif
      end else begin
         state_q   <= state_nx;
         // Timer restarts on every state change, including VRD_SAMPLE->VRD_ADDR.
         tmr_q     <= (state_nx != state_q) ? '0 : tmr_q + 16'd1;
         // Strobes decoded from the next state so they line up with state_q.
         SRAM_WE_n <= (state_nx != PULSE);
         data_oe_q <= (state_nx == SETUP) || (state_nx == PULSE) || (state_nx == HOLD);
         dl_ready  <= (state_nx == WAIT_DATA);
         sram_own  <= own_nx;
         busy      <= own_nx;
         done      <= (state_nx == DONE);

         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  cnt_q    <= '0;
                  checksum <= '0;
                  error    <= 1'b0;
                  addr_q   <= ADDR_BASE;
               end
            end
            WAIT_DATA: if (dl_valid) last_q <= dl_last;
            HOLD: begin
               cnt_q    <= cnt_inc;
               checksum <= checksum + byte_q;
               if (!last_q && (cnt_inc == 18'(MAX_BYTES))) error <= 1'b1;
`ifdef BIOS_SRAM_LOADER_VERIFY_EN
               // The write phase always ends here when last or full, so the
               // read-back pointer is rewound on those exits only.
               if (state_nx == VRD_ADDR) begin
                  addr_q <= ADDR_BASE;
                  vidx_q <= '0;
               end else begin
                  addr_q <= addr_q + 1'b1;
               end
`else
               addr_q   <= addr_q + 1'b1;
`endif
            end
`ifdef BIOS_SRAM_LOADER_VERIFY_EN
            VRD_SAMPLE: begin
               if (state_nx == DONE) begin
                  if (vsum_nx != checksum) error <= 1'b1;
               end else begin
                  vidx_q <= vidx_q + 18'd1;
                  addr_q <= addr_q + 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   // Data-path registers: no reset, only qualified loads
   always_ff @(posedge clka) begin
      if ((state_q == WAIT_DATA) && dl_valid) byte_q <= dl_data;
`ifdef BIOS_SRAM_LOADER_VERIFY_EN
      if (state_q == HOLD)            vsum_q <= '0;
      else if (state_q == VRD_SAMPLE) vsum_q <= vsum_nx;
`endif
   end

endmodule

// File: tb/tb_bios_sram_loader.sv
// Testbench for bios_sram_loader (BASE_ADDR=0x10000, MAX_BYTES=4, default
// timing). Table vectors, hand-written corner sequences and a randomized
// loop checked against a byte-stream reference model.
module tb_bios_sram_loader;
   localparam int ADDR_W = 21;
   localparam int BASE   = 32'h10000;
   localparam int MAXB   = 4;

   logic        clka = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        dl_valid = 1'b0;
   logic [7:0]  dl_data = 8'h00;
   logic        dl_last = 1'b0;
   logic        dl_ready;
   logic [20:0] SRAM_ADDR;
   wire  [7:0]  SRAM_DATA;
   logic        SRAM_WE_n;
   logic        sram_own;
   logic        busy;
   logic        done;
   logic        error;
   logic [16:0] byte_count;
   logic [7:0]  checksum;

   int total = 0;
   int bad   = 0;

   bios_sram_loader #(
      .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAX_BYTES(MAXB),
      .SETUP_CYCLES(1), .WE_CYCLES(2), .READ_CYCLES(2)
   ) dut (
      .clka(clka), .rst_n(rst_n), .start(start),
      .dl_valid(dl_valid), .dl_data(dl_data), .dl_last(dl_last),
      .dl_ready(dl_ready), .SRAM_ADDR(SRAM_ADDR), .SRAM_DATA(SRAM_DATA),
      .SRAM_WE_n(SRAM_WE_n), .sram_own(sram_own), .busy(busy),
      .done(done), .error(error), .byte_count(byte_count), .checksum(checksum)
   );

   always #5 clka = ~clka;

   // SRAM model: small array indexed by the low address bits
   logic [7:0] mem [0:15];
   bit         stuck3 = 1'b0;
`ifdef BIOS_SRAM_LOADER_VERIFY_EN
   int  vr_n = 0;
   wire rd_drv = sram_own && SRAM_WE_n && (byte_count == 17'(vr_n));
   assign SRAM_DATA = rd_drv ? mem[SRAM_ADDR[3:0]] : 8'bz;
`endif

   // Write monitor: one record per WE_n low pulse
   logic [20:0] wr_addr [$];
   logic [7:0]  wr_data [$];
   int          wr_len  [$];
   int          fall_cyc[$];
   int          stable_err = 0;
   int          cyc = 0;

   initial begin
      logic        we_prev;
      logic [20:0] lo_addr;
      logic [7:0]  lo_data;
      int          lo_len;
      we_prev = 1'b1; lo_addr = '0; lo_data = '0; lo_len = 0;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      forever begin
         @(negedge clka);
         cyc++;
         if (!SRAM_WE_n) begin
            if (we_prev) begin
               lo_addr = SRAM_ADDR; lo_data = SRAM_DATA; lo_len = 0;
               fall_cyc.push_back(cyc);
            end else if (SRAM_ADDR !== lo_addr || SRAM_DATA !== lo_data) begin
               stable_err++;
            end
            lo_len++;
         end else if (!we_prev) begin
            wr_addr.push_back(lo_addr);
            wr_data.push_back(lo_data);
            wr_len.push_back(lo_len);
            mem[lo_addr[3:0]] = stuck3 ? (lo_data & 8'hF7) : lo_data;
         end
         we_prev = SRAM_WE_n;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
      $fatal(1, "watchdog");
   end

   // Stimulus byte stream
   logic [7:0] tx_bytes [0:15];
   int         tx_len;
   int         tx_last_idx;
   int         tx_gap;

   typedef struct {
      logic [7:0] first;
      logic [7:0] step;
      int         len;
      int         last_idx;   // -1: no dl_last in the stream
      int         gap;
      int         exp_count;
      logic [7:0] exp_sum;
      logic       exp_err;
   } vec_t;
   vec_t vecs [0:5];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clr();
      wr_addr.delete(); wr_data.delete(); wr_len.delete(); fall_cyc.delete();
      stable_err = 0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clka);
      start = 1'b0;
   endtask

   // Offer one byte; called and returning at a falling edge.
   task automatic send_byte(input logic [7:0] d, input bit l, output bit ok);
      bit rdy;
      ok = 1'b0;
      dl_valid = 1'b1; dl_data = d; dl_last = l;
      for (int c = 0; c < 40 && !ok; c++) begin
         rdy = dl_ready;
         @(posedge clka);
         if (rdy) ok = 1'b1;
         @(negedge clka);
      end
      dl_valid = 1'b0; dl_last = 1'b0;
   endtask

   task automatic send_stream(output int acc);
      bit ok;
      acc = 0;
      for (int i = 0; i < tx_len; i++) begin
         send_byte(tx_bytes[i], (i == tx_last_idx), ok);
         if (!ok) break;
         acc++;
         for (int g = 0; g < tx_gap; g++) @(negedge clka);
      end
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      while (!done && n < 300) begin
         @(negedge clka);
         n++;
      end
      if (!done) check({nm, ".done_timeout"}, 32'(done), 32'd1);
   endtask

   // Reference model: the block writes bytes up to and including the first
   // dl_last, but never more than MAXB; hitting MAXB without last is an error.
   task automatic model(output int k, output logic [7:0] sum, output logic err);
      if (tx_last_idx >= 0 && tx_last_idx < MAXB) begin
         k = tx_last_idx + 1; err = 1'b0;
      end else begin
         k = MAXB; err = 1'b1;
      end
      sum = 8'h00;
      for (int i = 0; i < k; i++) sum = sum + tx_bytes[i];
   endtask

   task automatic check_load(input string nm, input int k, input logic [7:0] sum,
                             input logic err, input int acc);
      check({nm, ".accepted"}, 32'(acc), 32'(k));
      check({nm, ".writes"}, 32'(wr_addr.size()), 32'(k));
      for (int i = 0; i < wr_addr.size() && i < k; i++) begin
         check($sformatf("%s.addr%0d", nm, i), 32'(wr_addr[i]), 32'((BASE + i) % (1 << ADDR_W)));
         check($sformatf("%s.data%0d", nm, i), 32'(wr_data[i]), 32'(tx_bytes[i]));
         check($sformatf("%s.we_len%0d", nm, i), 32'(wr_len[i]), 32'd2);
      end
      if (tx_gap <= 4)
         for (int i = 1; i < fall_cyc.size(); i++)
            check($sformatf("%s.spacing%0d", nm, i), 32'(fall_cyc[i] - fall_cyc[i-1]), 32'd5);
      check({nm, ".stable"},     32'(stable_err), 32'd0);
      check({nm, ".byte_count"}, 32'(byte_count), 32'(k));
      check({nm, ".checksum"},   32'(checksum),   32'(sum));
      check({nm, ".error"},      32'(error),      32'(err));
      check({nm, ".done"},       32'(done),       32'd1);
      check({nm, ".busy"},       32'(busy),       32'd0);
      check({nm, ".own"},        32'(sram_own),   32'd0);
      check({nm, ".dl_ready"},   32'(dl_ready),   32'd0);
      check({nm, ".we_n"},       32'(SRAM_WE_n),  32'd1);
   endtask

   task automatic check_reset_vals(input string nm);
      check({nm, ".we_n"},       32'(SRAM_WE_n),  32'd1);
      check({nm, ".data_z"},     32'((SRAM_DATA === 8'bz) || (SRAM_DATA === 8'h00)), 32'd1);
      check({nm, ".addr"},       32'(SRAM_ADDR),  32'd0);
      check({nm, ".dl_ready"},   32'(dl_ready),   32'd0);
      check({nm, ".own"},        32'(sram_own),   32'd0);
      check({nm, ".busy"},       32'(busy),       32'd0);
      check({nm, ".done"},       32'(done),       32'd0);
      check({nm, ".error"},      32'(error),      32'd0);
      check({nm, ".byte_count"}, 32'(byte_count), 32'd0);
      check({nm, ".checksum"},   32'(checksum),   32'd0);
   endtask

   task automatic set_vr(input int n);
`ifdef BIOS_SRAM_LOADER_VERIFY_EN
      vr_n = n;
`else
      if (n < 0) $display("negative verify length %0d", n);
`endif
   endtask

   initial begin
      int         acc;
      int         k;
      logic [7:0] sum;
      logic       err;
      bit         ok;

      vecs[0] = '{8'h11, 8'h11, 4, 3,  0, 4, 8'hAA, 1'b0};
      vecs[1] = '{8'h80, 8'h40, 2, 1,  7, 2, 8'h40, 1'b0};
      vecs[2] = '{8'hFF, 8'h01, 1, 0,  0, 1, 8'hFF, 1'b0};
      vecs[3] = '{8'h01, 8'h01, 6, -1, 0, 4, 8'h0A, 1'b1};
      vecs[4] = '{8'hF0, 8'h10, 3, 2,  3, 3, 8'h00, 1'b0};
      vecs[5] = '{8'h01, 8'h01, 6, 4,  0, 4, 8'h0A, 1'b1};

      repeat (3) @(negedge clka);
      check_reset_vals("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clka);
      check("idle.own", 32'(sram_own), 32'd0);

      // Table-driven loads
      foreach (vecs[v]) begin
         tx_len = vecs[v].len; tx_last_idx = vecs[v].last_idx; tx_gap = vecs[v].gap;
         for (int i = 0; i < tx_len; i++) tx_bytes[i] = vecs[v].first + 8'(i) * vecs[v].step;
         set_vr(vecs[v].exp_count);
         clr();
         do_start();
         check($sformatf("vec%0d.start_addr", v), 32'(SRAM_ADDR), 32'(BASE));
         check($sformatf("vec%0d.start_ready", v), 32'(dl_ready), 32'd1);
         send_stream(acc);
         wait_done($sformatf("vec%0d", v));
         check_load($sformatf("vec%0d", v), vecs[v].exp_count, vecs[v].exp_sum, vecs[v].exp_err, acc);
      end

      // dl_valid low for 7 clocks between bytes
      set_vr(2); clr(); do_start();
      send_byte(8'h5A, 1'b0, ok);
      check("gap.acc0", 32'(ok), 32'd1);
      begin
         int lows;
         lows = 0;
         for (int g = 0; g < 7; g++) begin
            @(negedge clka);
            if (!SRAM_WE_n && g >= 3) lows++;
         end
         check("gap.we_idle", 32'(lows), 32'd0);
      end
      send_byte(8'hA5, 1'b1, ok);
      check("gap.setup_we", 32'(SRAM_WE_n), 32'd1);
      check("gap.setup_data", 32'(SRAM_DATA), 32'hA5);
      @(negedge clka);
      check("gap.pulse_we", 32'(SRAM_WE_n), 32'd0);
      wait_done("gap");
      check("gap.count", 32'(byte_count), 32'd2);
      check("gap.sum", 32'(checksum), 32'hFF);

      // start pulsed during PULSE is ignored
      set_vr(2); clr(); do_start();
      send_byte(8'h11, 1'b0, ok);
      @(negedge clka);
      check("spulse.in_pulse", 32'(SRAM_WE_n), 32'd0);
      do_start();
      send_byte(8'h22, 1'b1, ok);
      wait_done("spulse");
      check("spulse.count", 32'(byte_count), 32'd2);
      check("spulse.sum", 32'(checksum), 32'h33);
      check("spulse.error", 32'(error), 32'd0);

      // Asynchronous reset during PULSE
      set_vr(1); clr(); do_start();
      send_byte(8'h44, 1'b0, ok);
      @(negedge clka);
      check("rstp.in_pulse", 32'(SRAM_WE_n), 32'd0);
      check("rstp.driven", 32'(SRAM_DATA), 32'h44);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("rstp");
      @(negedge clka);
      rst_n = 1'b1;
      @(negedge clka);
      #1 clr();

      // Randomized loads against the model
      for (int r = 0; r < 25; r++) begin
         if ($urandom_range(0, 3) == 0) begin
            tx_len = MAXB + 1 + $urandom_range(0, 1);
            tx_last_idx = -1;
         end else begin
            tx_len = $urandom_range(1, 6);
            tx_last_idx = $urandom_range(0, tx_len - 1);
         end
         tx_gap = $urandom_range(0, 3);
         for (int i = 0; i < tx_len; i++) tx_bytes[i] = 8'($urandom);
         model(k, sum, err);
         set_vr(k);
         clr();
         do_start();
         send_stream(acc);
         wait_done($sformatf("rnd%0d", r));
         check_load($sformatf("rnd%0d", r), k, sum, err, acc);
      end

`ifdef BIOS_SRAM_LOADER_VERIFY_EN
      // Read-back with data bit 3 stuck low, then with a clean model
      for (int s = 1; s >= 0; s--) begin
         stuck3 = (s == 1);
         tx_len = 1; tx_last_idx = 0; tx_gap = 0; tx_bytes[0] = 8'h08;
         set_vr(1); clr(); do_start();
         send_stream(acc);
         wait_done($sformatf("verify%0d", s));
         check($sformatf("verify%0d.error", s), 32'(error), 32'(s));
         check($sformatf("verify%0d.done", s), 32'(done), 32'd1);
         check($sformatf("verify%0d.sum", s), 32'(checksum), 32'h08);
      end
      stuck3 = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bios_sram_loader.md
# bios_sram_loader

Streaming writer that fills the external BIOS SRAM from the download interface before the CPU runs. It accepts bytes over a valid/ready handshake and issues timed write cycles on SRAM_ADDR/SRAM_DATA/SRAM_WE_n. It owns the bus only while `sram_own` is high; the top level muxes the pins between this block and the CPU-side SRAM reader. The block keeps a byte count and a running checksum, and can optionally verify the load by reading it back.

## Interface
- ADDR_W, 21, SRAM address width
- BASE_ADDR, 0, SRAM address of the first byte
- MAX_BYTES, 65536, capacity in bytes; range 1..2^17
- SETUP_CYCLES, 1, clocks that address and data are stable before WE_n falls; minimum 1
- WE_CYCLES, 2, clocks that WE_n is low; minimum 1
- READ_CYCLES, 2, clocks from address valid to sample during verify; minimum 1

- clka in 1: system clock; all logic runs on the rising edge
- rst_n in 1: asynchronous active-low reset
- start in 1: one-clock pulse; begins a load from IDLE or DONE
- dl_valid in 1: download byte valid
- dl_data in 8: download byte
- dl_last in 1: marks the final byte, qualified by dl_valid
- dl_ready out 1: block can accept a byte
- SRAM_ADDR out ADDR_W: SRAM address
- SRAM_DATA inout 8: SRAM data; driven only in SETUP/PULSE/HOLD, otherwise high-Z
- SRAM_WE_n out 1: SRAM write strobe, active low
- sram_own out 1: loader owns the SRAM pins
- busy out 1: a load or verify is in progress
- done out 1: load finished; held until the next start
- error out 1: overflow or verify mismatch; held until the next start
- byte_count out 17: bytes written
- checksum out 8: sum of the written bytes, mod 256

## Operation
- States: IDLE, WAIT_DATA, SETUP, PULSE, HOLD, DONE. The VRD_ADDR and VRD_SAMPLE states exist only with the macro enabled.
- IDLE / DONE, start=1: clear byte_count, checksum, done, error; set the address pointer to BASE_ADDR; go to WAIT_DATA.
- A start pulse in any other state is ignored.
- WAIT_DATA: dl_ready=1. On dl_valid&dl_ready, latch the byte and dl_last, then go to SETUP. dl_ready=0 in every other state.
- SETUP: SRAM_DATA driven with the byte, WE_n=1, for SETUP_CYCLES clocks, then PULSE.
- PULSE: WE_n=0 for WE_CYCLES clocks, then HOLD.
- HOLD: WE_n=1 and data still driven, for 1 clock. On exit: byte_count+=1, checksum+=byte, address+=1.
- Next state after HOLD:
  - last byte → DONE, or VRD_ADDR when verify is enabled.
  - byte_count has reached MAX_BYTES without last → error=1, then DONE / VRD_ADDR. Any further bytes are not accepted.
  - otherwise → WAIT_DATA.
- Address arithmetic is BASE_ADDR + count, ADDR_W bits, wrapping modulo 2^ADDR_W.
- sram_own=1 in every state except IDLE and DONE. busy equals sram_own.
- done=1 while in DONE.

## Timing
- Reset values: SRAM_WE_n=1, SRAM_DATA high-Z, SRAM_ADDR=0, dl_ready=0, sram_own=0, busy=0, done=0, error=0, byte_count=0, checksum=0, state IDLE.
- Reset asserted mid-cycle (including during PULSE) forces WE_n high and releases the bus immediately, without waiting for a clock.
- Write cycle: SETUP_CYCLES+WE_CYCLES+1 clocks per byte. The accept in WAIT_DATA adds at least 1 clock, so peak throughput is 1 byte per SETUP_CYCLES+WE_CYCLES+2 clocks (5 with defaults).
- SRAM_ADDR and data never change while WE_n=0.
- All outputs are registered.
- done rises on the clock after the final HOLD, or after the final verify sample.

## Configuration
- BIOS_SRAM_LOADER_VERIFY_EN defined:
  - After the write phase, reread addresses BASE_ADDR .. BASE_ADDR+byte_count-1 with WE_n=1 and data high-Z.
  - Each address is held READ_CYCLES clocks in VRD_ADDR, then sampled in VRD_SAMPLE.
  - The samples are summed mod 256. If the sum differs from checksum, set error=1. Then go to DONE.
  - When byte_count=0, go directly to DONE.
- Macro undefined: the verify states and logic are absent; HOLD goes directly to DONE.

## Test plan
- Load bytes 0x11,0x22,0x33,0x44 (last on 0x44), BASE_ADDR=0x10000 → writes at 0x10000..0x10003, byte_count=4, checksum=0xAA, done=1, error=0.
- dl_valid dropped low for 7 clocks between bytes → WE_n stays high, and the next write starts 1 clock after the accept.
- MAX_BYTES=4, stream 6 bytes with no last → exactly 4 writes, dl_ready stays 0 afterwards, error=1, done=1.
- start pulsed while in PULSE → ignored; count and checksum are unchanged.
- rst_n=0 during PULSE → WE_n=1 and SRAM_DATA high-Z in the same cycle; all outputs return to their reset values.
- VERIFY_EN defined, SRAM model with data bit 3 stuck at 0, load 0x08 → error=1, done=1. With a clean model → error=0.
